// File: rtl/inert_disp_pkg.sv
// inert_disp_pkg
// Shared definitions for the inert display selector slice.
//   state_e        : controller states (IDLE, CAL, SHOW, FAULT)
//   LED_FAULT_ALL  : all-ones pattern shown on the display in FAULT;
//                    consumers slice off the low LED_W bits.
package inert_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAL   = 2'd1,
    SHOW  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int LED_FAULT_MAX_W = 64;
  localparam logic [LED_FAULT_MAX_W-1:0] LED_FAULT_ALL = '1;

endpackage

// File: rtl/inert_disp_fmt.sv
// inert_disp_fmt
// Combinational display formatter: turns one channel word into the LED
// display value.
//   ch  : channel word (CH_W bits)
//   led : display value (LED_W bits)
// Configuration macro: INERT_DISP_SAT_EN
//   undefined : plain truncating slice ch[LSB_OFS +: LED_W]
//   defined   : signed channel, arithmetic shift right by LSB_OFS, then
//               clamp to the two's-complement range of LED_W bits
module inert_disp_fmt #(
  parameter int CH_W    = 16,
  parameter int LED_W   = 8,
  parameter int LSB_OFS = 1
) (
  input  logic [CH_W-1:0]  ch,
  output logic [LED_W-1:0] led
);

`ifdef INERT_DISP_SAT_EN
  localparam int MAX_I = (1 << (LED_W - 1)) - 1;
  localparam logic signed [CH_W-1:0] MAX_V = CH_W'(MAX_I);
  localparam logic signed [CH_W-1:0] MIN_V = CH_W'(-MAX_I - 1);

  logic signed [CH_W-1:0] shifted;

  // Shift keeps the sign, so out-of-range values clamp to the nearest
  // representable LED code instead of wrapping.
  always_comb begin
    shifted = $signed(ch) >>> LSB_OFS;
    if (shifted > MAX_V) begin
      led = {1'b0, {(LED_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      led = {1'b1, {(LED_W-1){1'b0}}};
    end else begin
      led = shifted[LED_W-1:0];
    end
  end
`else
  // Bits outside the display window are intentionally dropped.
  logic unused_ch;
  assign unused_ch = ^ch;
  assign led       = ch[LSB_OFS +: LED_W];
`endif

endmodule

// File: rtl/inert_disp_sel.sv
// inert_disp_sel
// Calibration-gated channel display selector. After reset it pulses
// strt_cal, waits for cal_done (or times out into FAULT), then shows one
// snapshotted channel on LED, selected manually (next/prev) or by auto-cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cal_done     : calibration complete level
//   vld, ch_data : snapshot strobe and packed channel data (ch k at k*CH_W)
//   next, prev   : one-cycle advance / retreat pulses
//   auto_en      : auto-cycle enable (DWELL cycles per channel)
//   strt_cal     : calibration start pulse (first cycle after reset)
//   cal_fail     : calibration timeout flag
//   ch_sel       : displayed channel
//   LED          : registered display value
// Configuration macro: INERT_DISP_SAT_EN (saturating formatting, see
// inert_disp_fmt).
module inert_disp_sel
  import inert_disp_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CH_W    = 16,
  parameter int LED_W   = 8,
  parameter int LSB_OFS = 1,
  parameter int DWELL   = 50000000,
  parameter int CAL_TMO = 100000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cal_done,
  input  logic                      vld,
  input  logic [NUM_CH*CH_W-1:0]    ch_data,
  input  logic                      next,
  input  logic                      prev,
  input  logic                      auto_en,
  output logic                      strt_cal,
  output logic                      cal_fail,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic [LED_W-1:0]          LED
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CAL_W = $clog2(CAL_TMO + 1);
  localparam int DW_W  = $clog2(DWELL + 1);

  state_e                 state_q, state_d;
  logic [CAL_W-1:0]       cal_cnt_q;
  logic [DW_W-1:0]        dwell_q;
  logic [SEL_W-1:0]       ch_sel_q;
  logic [NUM_CH*CH_W-1:0] snap_q;
  logic [LED_W-1:0]       led_q;
  logic [CH_W-1:0]        disp_ch;
  logic [LED_W-1:0]       fmt_led;

  logic show;
  logic cal_tmo;
  logic dwell_end;
  logic step_up;
  logic step_dn;

  assign show      = (state_q == SHOW);
  assign cal_tmo   = (cal_cnt_q == CAL_W'(CAL_TMO - 1));
  assign dwell_end = (dwell_q == DW_W'(DWELL - 1));

  // A manual pulse beats the dwell advance; next and prev together cancel.
  assign step_up = show && ((next && !prev) || (!next && !prev && auto_en && dwell_end));
  assign step_dn = show && prev && !next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // strt_cal is masked by rst so it stays low while reset is held and
  // pulses exactly on the first cycle after release. cal_done beats the
  // timeout when both land in the same cycle.
  always_comb begin
    state_d  = state_q;
    strt_cal = 1'b0;
    cal_fail = 1'b0;
    case (state_q)
      IDLE: begin
        strt_cal = !rst;
        state_d  = CAL;
      end
      CAL: begin
        if (cal_done) begin
          state_d = SHOW;
        end else if (cal_tmo) begin
          state_d = FAULT;
        end
      end
      SHOW: begin
        state_d = SHOW;
      end
      FAULT: begin
        cal_fail = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The counter never wraps: CAL is left once it reaches CAL_TMO-1.
  always_ff @(posedge clk) begin
    if (rst || state_q != CAL) begin
      cal_cnt_q <= '0;
    end else begin
      cal_cnt_q <= cal_cnt_q + CAL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !show || next || prev || !auto_en || dwell_end) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + DW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel_q <= '0;
    end else if (step_up) begin
      ch_sel_q <= (ch_sel_q == SEL_W'(NUM_CH - 1)) ? '0 : ch_sel_q + SEL_W'(1);
    end else if (step_dn) begin
      ch_sel_q <= (ch_sel_q == '0) ? SEL_W'(NUM_CH - 1) : ch_sel_q - SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (vld) begin
      snap_q <= ch_data;
    end
  end

  assign disp_ch = snap_q[ch_sel_q*CH_W +: CH_W];

  inert_disp_fmt #(
    .CH_W   (CH_W),
    .LED_W  (LED_W),
    .LSB_OFS(LSB_OFS)
  ) u_fmt (
    .ch (disp_ch),
    .led(fmt_led)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      case (state_q)
        SHOW:    led_q <= fmt_led;
        FAULT:   led_q <= LED_FAULT_ALL[LED_W-1:0];
        default: led_q <= '0;
      endcase
    end
  end

  assign ch_sel = ch_sel_q;
  assign LED    = led_q;

endmodule

// File: tb/tb_inert_disp_sel.sv
// tb_inert_disp_sel
// Directed and randomized bench for inert_disp_sel with a cycle-level
// reference model of the display selector. Build with +define+INERT_DISP_SAT_EN
// to exercise the saturating formatter.
module tb_inert_disp_sel;

  localparam int NUM_CH  = 3;
  localparam int CH_W    = 16;
  localparam int LED_W   = 8;
  localparam int LSB_OFS = 1;
  localparam int DWELL   = 4;
  localparam int CAL_TMO = 100;

  localparam int M_IDLE  = 0;
  localparam int M_CAL   = 1;
  localparam int M_SHOW  = 2;
  localparam int M_FAULT = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cal_done = 1'b0;
  logic                   vld = 1'b0;
  logic [NUM_CH*CH_W-1:0] ch_data = '0;
  logic                   next = 1'b0;
  logic                   prev = 1'b0;
  logic                   auto_en = 1'b0;
  logic                   strt_cal;
  logic                   cal_fail;
  logic [1:0]             ch_sel;
  logic [LED_W-1:0]       LED;

  int checks = 0;
  int errors = 0;

  int m_mode  = M_IDLE;
  int m_sel   = 0;
  int m_dwell = 0;
  int m_cal   = 0;
  int m_led   = 0;
  int m_snap[NUM_CH];

  inert_disp_sel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .LED_W  (LED_W),
    .LSB_OFS(LSB_OFS),
    .DWELL  (DWELL),
    .CAL_TMO(CAL_TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cal_done(cal_done),
    .vld     (vld),
    .ch_data (ch_data),
    .next    (next),
    .prev    (prev),
    .auto_en (auto_en),
    .strt_cal(strt_cal),
    .cal_fail(cal_fail),
    .ch_sel  (ch_sel),
    .LED     (LED)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Display formatting computed directly from arithmetic on the channel value.
  function automatic int fmt_ref(input int raw);
    int d;
    int v;
    d = 1 << LSB_OFS;
`ifdef INERT_DISP_SAT_EN
    v = (raw >= (1 << (CH_W - 1))) ? raw - (1 << CH_W) : raw;
    v = (v >= 0) ? v / d : (v - (d - 1)) / d;
    if (v > (1 << (LED_W - 1)) - 1) v = (1 << (LED_W - 1)) - 1;
    if (v < -(1 << (LED_W - 1))) v = -(1 << (LED_W - 1));
    return v & ((1 << LED_W) - 1);
`else
    v = raw;
    return (v / d) % (1 << LED_W);
`endif
  endfunction

  // Advance the reference by one clock edge using the inputs present at it.
  task automatic model_step();
    int new_led;
    if (rst) begin
      m_mode  = M_IDLE;
      m_sel   = 0;
      m_dwell = 0;
      m_cal   = 0;
      m_led   = 0;
      for (int k = 0; k < NUM_CH; k++) m_snap[k] = 0;
    end else begin
      if (m_mode == M_SHOW) new_led = fmt_ref(m_snap[m_sel]);
      else if (m_mode == M_FAULT) new_led = (1 << LED_W) - 1;
      else new_led = 0;
      case (m_mode)
        M_IDLE: begin
          m_mode = M_CAL;
          m_cal  = 0;
        end
        M_CAL: begin
          if (cal_done) m_mode = M_SHOW;
          else if (m_cal == CAL_TMO - 1) m_mode = M_FAULT;
          else m_cal++;
          m_dwell = 0;
        end
        M_SHOW: begin
          if (next && !prev) m_sel = (m_sel + 1) % NUM_CH;
          else if (prev && !next) m_sel = (m_sel + NUM_CH - 1) % NUM_CH;
          else if (!next && !prev && auto_en && m_dwell == DWELL - 1)
            m_sel = (m_sel + 1) % NUM_CH;
          if (next || prev || !auto_en || m_dwell == DWELL - 1) m_dwell = 0;
          else m_dwell++;
        end
        default: begin
        end
      endcase
      if (vld) begin
        for (int k = 0; k < NUM_CH; k++) m_snap[k] = int'(ch_data[k*CH_W +: CH_W]);
      end
      m_led = new_led;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".strt_cal"}, 32'(strt_cal), 32'((m_mode == M_IDLE) && !rst));
    check({tag, ".cal_fail"}, 32'(cal_fail), 32'(m_mode == M_FAULT));
    check({tag, ".ch_sel"},   32'(ch_sel),   32'(m_sel));
    check({tag, ".LED"},      32'(LED),      32'(m_led));
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clk);
    model_step();
    #1;
    checkOutput(tag);
  endtask

  task automatic set_ch(input int c0, input int c1, input int c2);
    ch_data = {16'(c2), 16'(c1), 16'(c0)};
  endtask

  initial begin
    int exp_sel[3];
    int sat_in[3];
    int sat_exp[3];
    int led_154;

    exp_sel = '{1, 2, 0};
    sat_in  = '{32'hFF00, 32'h0100, 32'h00FE};
`ifdef INERT_DISP_SAT_EN
    sat_exp = '{32'h80, 32'h7F, 32'h7F};
    led_154 = 32'h7F;
`else
    sat_exp = '{32'h80, 32'h80, 32'h7F};
    led_154 = 32'hAA;
`endif
    for (int k = 0; k < NUM_CH; k++) m_snap[k] = 0;
    $display("[TB] start");

    // Reset held, then the single IDLE cycle with strt_cal.
    rst = 1'b1;
    repeat (3) applyStimulus("rst");
    check("rst_led", 32'(LED), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("idle");
    check("strt_first", 32'(strt_cal), 32'h1);
    repeat (10) applyStimulus("cal");
    check("strt_gone", 32'(strt_cal), 32'h0);
    check("cal_led", 32'(LED), 32'h0);
    cal_done = 1'b1;
    applyStimulus("to_show");
    cal_done = 1'b0;
    check("show_sel", 32'(ch_sel), 32'h0);

    // Snapshot and two-cycle display latency.
    set_ch(32'h0154, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    vld = 1'b1;
    applyStimulus("vld");
    vld = 1'b0;
    applyStimulus("vld_p1");
    check("led_0154", 32'(LED), 32'(led_154));

    // Manual navigation.
    for (int i = 0; i < 3; i++) begin
      next = 1'b1;
      applyStimulus("next");
      next = 1'b0;
      check("next_sel", 32'(ch_sel), 32'(exp_sel[i]));
    end
    prev = 1'b1;
    applyStimulus("prev");
    prev = 1'b0;
    check("prev_wrap", 32'(ch_sel), 32'h2);
    next = 1'b1;
    prev = 1'b1;
    applyStimulus("both");
    next = 1'b0;
    prev = 1'b0;
    check("both_hold", 32'(ch_sel), 32'h2);

    // Auto-cycle and manual restart of the dwell.
    auto_en = 1'b1;
    repeat (3) applyStimulus("auto");
    check("auto_pre", 32'(ch_sel), 32'h2);
    applyStimulus("auto");
    check("auto_adv", 32'(ch_sel), 32'h0);
    repeat (2) applyStimulus("auto");
    next = 1'b1;
    applyStimulus("auto_next");
    next = 1'b0;
    check("auto_manual", 32'(ch_sel), 32'h1);
    repeat (3) applyStimulus("auto");
    check("auto_restart_pre", 32'(ch_sel), 32'h1);
    applyStimulus("auto");
    check("auto_restart", 32'(ch_sel), 32'h2);
    auto_en = 1'b0;

    // Randomized operation in SHOW.
    repeat (300) begin
      next    = ($urandom_range(0, 5) == 0);
      prev    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
      vld     = ($urandom_range(0, 3) == 0);
      ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      applyStimulus("rand");
    end
    next    = 1'b0;
    prev    = 1'b0;
    auto_en = 1'b0;
    vld     = 1'b0;

    // Formatter boundary values on every channel.
    for (int i = 0; i < 3; i++) begin
      set_ch(sat_in[i], sat_in[i], sat_in[i]);
      vld = 1'b1;
      applyStimulus("fmt_vld");
      vld = 1'b0;
      applyStimulus("fmt_p1");
      check("fmt_boundary", 32'(LED), 32'(sat_exp[i]));
    end

    // cal_done on the last timeout cycle still wins.
    rst = 1'b1;
    applyStimulus("rst2");
    rst = 1'b0;
    #1;
    checkOutput("idle2");
    applyStimulus("cal2");
    set_ch(32'h0154, 32'h0154, 32'h0154);
    vld = 1'b1;
    applyStimulus("cal2_vld");
    vld = 1'b0;
    repeat (98) applyStimulus("cal2");
    cal_done = 1'b1;
    applyStimulus("cal2_done");
    cal_done = 1'b0;
    check("tmo_edge_nofail", 32'(cal_fail), 32'h0);
    repeat (2) applyStimulus("show2");
    check("tmo_edge_show", 32'(LED), 32'(led_154));

    // Timeout into FAULT, which ignores everything but reset.
    rst = 1'b1;
    applyStimulus("rst3");
    rst = 1'b0;
    #1;
    checkOutput("idle3");
    applyStimulus("cal3");
    repeat (99) applyStimulus("cal3");
    check("pre_tmo", 32'(cal_fail), 32'h0);
    applyStimulus("tmo");
    check("fault_flag", 32'(cal_fail), 32'h1);
    applyStimulus("fault");
    check("fault_led", 32'(LED), 32'hFF);
    cal_done = 1'b1;
    next     = 1'b1;
    auto_en  = 1'b1;
    repeat (10) begin
      prev    = $urandom_range(0, 1) == 1;
      vld     = 1'b1;
      ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      applyStimulus("fault_ign");
    end
    check("fault_keep", 32'(cal_fail), 32'h1);
    check("fault_sel", 32'(ch_sel), 32'h0);
    check("fault_led2", 32'(LED), 32'hFF);
    rst = 1'b1;
    applyStimulus("rst_fault");
    check("rst_fault_flag", 32'(cal_fail), 32'h0);
    check("rst_fault_led", 32'(LED), 32'h0);
    check("rst_fault_strt", 32'(strt_cal), 32'h0);

    // Reset beats a simultaneous next in SHOW.
    cal_done = 1'b0;
    next     = 1'b0;
    prev     = 1'b0;
    auto_en  = 1'b0;
    vld      = 1'b0;
    rst      = 1'b0;
    #1;
    checkOutput("idle4");
    applyStimulus("cal4");
    cal_done = 1'b1;
    applyStimulus("show4");
    cal_done = 1'b0;
    next = 1'b1;
    applyStimulus("next4");
    check("next4_sel", 32'(ch_sel), 32'h1);
    rst = 1'b1;
    applyStimulus("rst_next");
    next = 1'b0;
    check("rst_wins_sel", 32'(ch_sel), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("idle5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inert_disp_sel.md
INERT_DISP_SEL -- requirements
Module: inert_disp_sel

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- NUM_CH, 3, channel count (>=2).
- CH_W, 16, channel width.
- LED_W, 8, display width.
- LSB_OFS, 1, display slice LSB (LSB_OFS+LED_W <= CH_W).
- DWELL, 50000000, auto-cycle cycles per channel.
- CAL_TMO, 100000000, calibration timeout in cycles.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- cal_done, in, 1, calibration complete level.
- vld, in, 1, ch_data valid pulse.
- ch_data, in, NUM_CH*CH_W, channel k at [k*CH_W +: CH_W].
- next, in, 1, one-cycle advance pulse.
- prev, in, 1, one-cycle retreat pulse.
- auto_en, in, 1, auto-cycle enable.
- strt_cal, out, 1, calibration start pulse.
- cal_fail, out, 1, calibration timeout flag.
- ch_sel, out, $clog2(NUM_CH), displayed channel.
- LED, out, LED_W, display value.

Function
REQ-004 FSM states SHALL be IDLE, CAL, SHOW and FAULT.
REQ-005 IDLE SHALL last exactly one cycle, assert strt_cal for that cycle only, and go to CAL.
REQ-006 CAL SHALL count cycles; cal_done=1 SHALL go to SHOW; count reaching CAL_TMO-1 with cal_done=0 SHALL go to FAULT; if both occur in the same cycle, cal_done SHALL win.
REQ-007 FAULT SHALL be absorbing until rst, set cal_fail=1 and LED to all ones, and ignore cal_done, next, prev and auto_en.
REQ-008 In SHOW, next SHALL increment ch_sel, wrapping from NUM_CH-1 to 0.
REQ-009 In SHOW, prev SHALL decrement ch_sel, wrapping from 0 to NUM_CH-1.
REQ-010 next and prev asserted in the same cycle SHALL leave ch_sel unchanged.
REQ-011 In SHOW with auto_en=1, a dwell counter SHALL advance ch_sel as next does when it reaches DWELL-1, then restart at 0.
REQ-012 Any next or prev pulse, or auto_en=0, SHALL clear the dwell counter; a manual pulse SHALL take priority over the dwell advance in the same cycle.
REQ-013 Outside SHOW, next, prev and the dwell counter SHALL be ignored and ch_sel held.
REQ-014 vld SHALL capture all ch_data into a snapshot register in any state; snapshot reset value SHALL be 0.
REQ-015 In SHOW, LED SHALL be registered from fmt(snapshot[ch_sel]).
- vld at cycle t: snapshot at t+1, LED at t+2.
- ch_sel change at t+1: LED at t+2.
REQ-016 In IDLE and CAL, LED SHALL be 0.
REQ-017 fmt SHALL be the unsigned slice [LSB_OFS +: LED_W] unless REQ-022 applies.

Reset
REQ-018 rst SHALL set state=IDLE, strt_cal=0, cal_fail=0, ch_sel=0, LED=0, and clear both counters and the snapshot.
REQ-019 rst SHALL win over every other input in the same cycle and SHALL abort any operation, including FAULT.
REQ-020 The first cycle after rst deasserts SHALL be IDLE, so the strt_cal pulse occurs on that cycle.

Configuration
REQ-021 Macro INERT_DISP_SAT_EN SHALL select saturating display formatting.
REQ-022 With INERT_DISP_SAT_EN defined, fmt SHALL treat the channel as signed, arithmetic-shift it right by LSB_OFS, and clamp to [-2^(LED_W-1), 2^(LED_W-1)-1] in two's complement.
REQ-023 Without the macro, fmt SHALL be the plain truncating slice of REQ-017, with no saturation logic present.

Structure
REQ-024 Package inert_disp_pkg SHALL hold the state enum (IDLE, CAL, SHOW, FAULT) and the LED all-ones FAULT constant.
REQ-025 Formatting SHALL be the combinational sub-module inert_disp_fmt (CH_W, LED_W, LSB_OFS), containing the INERT_DISP_SAT_EN conditional.

Verification (NUM_CH=3, CH_W=16, LED_W=8, LSB_OFS=1, DWELL=4, CAL_TMO=100)
REQ-026 Release rst, assert cal_done 10 cycles later -> strt_cal high only in the first cycle, SHOW entered, ch_sel=0, LED=0 before SHOW.
REQ-027 In SHOW, vld with ch0=0x0154 -> LED=0xAA two cycles later without macro; LED=0x7F with the macro.
REQ-028 next x3 -> ch_sel 1,2,0; prev -> 2; next+prev in the same cycle -> ch_sel stays 2.
REQ-029 auto_en=1 -> ch_sel advances every 4 cycles; next pulse two cycles into a dwell -> immediate advance, then next auto advance 4 cycles later.
REQ-030 cal_done held 0 for 100 cycles -> FAULT, cal_fail=1, LED=0xFF; later cal_done and next ignored; rst -> IDLE, all outputs 0.
REQ-031 Macro defined, ch=0xFF00 -> LED=0x80; ch=0x0100 -> LED=0x7F; ch=0x00FE -> LED=0x7F.
